// File: rtl/des_pkg.sv
// Shared types and constants for the DES round sequencer: FSM states,
// datapath widths and the standard per-round key shift schedule.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int HALF_W = 32;
  localparam int CD_W   = 28;

  localparam logic [1:0] SHIFTS [1:16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Rotation amount for round cnt+1. Decrypt walks the schedule backwards and
  // skips round 1, because the 28-bit total brings CD back to K16's value.
  function automatic logic [1:0] shift_amt(input logic [3:0] cnt, input logic decrypt);
    logic [4:0] rnd;
    rnd = {1'b0, cnt} + 5'd1;
    if (!decrypt)
      return SHIFTS[rnd];
    if (rnd == 5'd1)
      return 2'd0;
    return SHIFTS[5'd18 - rnd];
  endfunction

endpackage

// File: rtl/des_round_ctrl_if.sv
// Block/key input handshake and pre-output handshake of the DES round sequencer.
interface des_round_ctrl_if;
  import des_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic                    in_decrypt;
  logic [2*HALF_W-1:0]     in_block;
  logic [2*CD_W-1:0]       in_key;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*HALF_W-1:0]     out_block;

  modport master (
    output in_valid, in_decrypt, in_block, in_key, out_ready,
    input  in_ready, out_valid, out_block
  );

  modport slave (
    input  in_valid, in_decrypt, in_block, in_key, out_ready,
    output in_ready, out_valid, out_block
  );

endinterface

// File: rtl/des_key_rotator.sv
// Combinational C/D key rotator: each 28-bit half is rotated independently
// by 0, 1 or 2 positions, left for encryption and right for decryption.
module des_key_rotator
  import des_pkg::*;
(
  input  logic [2*CD_W-1:0] cd,
  input  logic [1:0]        amount,
  input  logic              dir_right,
  output logic [2*CD_W-1:0] cd_rot
);

  function automatic logic [CD_W-1:0] rot_half(input logic [CD_W-1:0] x,
                                               input logic [1:0]      amt,
                                               input logic            right);
    logic [CD_W-1:0] y;
    case (amt)
      2'd1:    y = right ? {x[0], x[CD_W-1:1]}   : {x[CD_W-2:0], x[CD_W-1]};
      2'd2:    y = right ? {x[1:0], x[CD_W-1:2]} : {x[CD_W-3:0], x[CD_W-1:CD_W-2]};
      default: y = x;
    endcase
    return y;
  endfunction

  assign cd_rot = {rot_half(cd[2*CD_W-1:CD_W], amount, dir_right),
                   rot_half(cd[CD_W-1:0],      amount, dir_right)};

endmodule

// File: rtl/des_round_ctrl.sv
// DES round sequencer: accepts an IP-permuted block and PC-1 key, runs 16
// Feistel rounds against an external round function, then offers R16||L16.
module des_round_ctrl
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  des_round_ctrl_if.slave     bus,
  output logic [HALF_W-1:0]   f_r,
  output logic [2*CD_W-1:0]   f_cd,
  input  logic [HALF_W-1:0]   f_out,
  output logic [3:0]          round_idx,
  output logic                busy
);

  state_t              state;
  logic [HALF_W-1:0]   l_q;
  logic [HALF_W-1:0]   r_q;
  logic [2*CD_W-1:0]   cd_q;
  logic [3:0]          cnt;
  logic                mode;
  logic                in_ready_q;
  logic                busy_q;
  logic                out_valid_q;

  logic [1:0]          rot_amt;
  logic [2*CD_W-1:0]   cd_rot;

  // Outside ROUND the rotator passes CD through unchanged.
  always_comb begin
    rot_amt = 2'd0;
    if (state == ROUND)
      rot_amt = shift_amt(cnt, mode);
  end

  des_key_rotator u_rot (
    .cd        (cd_q),
    .amount    (rot_amt),
    .dir_right (mode),
    .cd_rot    (cd_rot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      l_q         <= '0;
      r_q         <= '0;
      cd_q        <= '0;
      cnt         <= '0;
      mode        <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            l_q        <= bus.in_block[2*HALF_W-1:HALF_W];
            r_q        <= bus.in_block[HALF_W-1:0];
            cd_q       <= bus.in_key;
            mode       <= bus.in_decrypt;
            cnt        <= '0;
            state      <= ROUND;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ROUND: begin
          l_q  <= r_q;
          r_q  <= l_q ^ f_out;
          cd_q <= cd_rot;
          // cnt wraps to 0 on the last round so round_idx reads 0 in DONE.
          cnt  <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign f_r           = r_q;
  assign f_cd          = cd_rot;
  assign round_idx     = cnt;
  assign busy          = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_block = {r_q, l_q};

endmodule
